v_bb_bitserial_driver: RTL and testbench
========================================

# v_bb_bitserial_driver

Bit-serial driver and collector for the two-input/one-output black-box cell. It accepts a pair of WIDTH-bit operands over a valid/ready handshake and shifts them LSB-first, one bit per cycle, onto the cell's two single-bit inputs. It samples the cell's output bit after a fixed pipeline delay and reassembles those bits into a WIDTH-bit result, presented over a second valid/ready handshake. The block sits directly upstream and downstream of the black-box instance and is its only driver and consumer.

## Interface
- WIDTH, 8: operand/result width in bits; legal range 2..32.
- BB_LAT, 0: cycles from di_1/di_2 change to the matching dout sample; legal range 0..7.

- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- a  input  WIDTH  operand routed to di_1.
- b  input  WIDTH  operand routed to di_2.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block can accept operands.
- di_1  output  1  serial bit to black-box in1.
- di_2  output  1  serial bit to black-box in2.
- dout  input  1  serial bit from black-box dout.
- res  output  WIDTH  reassembled result; bit i corresponds to operand bit i.
- res_valid  output  1  res valid.
- res_ready  input  1  consumer accepts res.

## Operation
- States:
  - IDLE: in_ready=1. On in_valid, load a and b into shift registers and enter SHIFT.
  - SHIFT: drive di_1=a_sh[0] and di_2=b_sh[0], then shift right. Stay for exactly WIDTH cycles, then go to DRAIN if BB_LAT>0, else HOLD.
  - DRAIN: wait BB_LAT cycles for the final samples, then go to HOLD.
  - HOLD: res_valid=1. On res_ready, go to IDLE.
- Bit capture:
  - A strobe, high during each SHIFT cycle, is delayed through a BB_LAT-stage register chain.
  - On each delayed strobe, dout is shifted into res from the MSB side (res <= {dout, res[WIDTH-1:1]}). After WIDTH captures, the first bit driven has landed in res[0].
- Counting: a bit counter of clog2(WIDTH+1) bits counts shifts and a separate counter counts captures. HOLD is entered only when the capture count reaches WIDTH.
- Outside SHIFT, di_1 and di_2 are driven 0.
- res is stable throughout HOLD.
- in_valid is ignored while not in IDLE (in_ready=0). No operand is lost, because the producer holds its operands until accepted.
- res_valid is never asserted outside HOLD.

## Timing
- Reset values: in_ready=1, di_1=0, di_2=0, res=0, res_valid=0; state=IDLE; all counters and the strobe chain cleared.
- Reset mid-operation: the operation in flight is discarded. The cycle after rst deasserts, the block is in IDLE with the reset values above.
- Operand acceptance at edge k (in_valid & in_ready).
- Bit i (0..WIDTH-1) is driven during cycle k+1+i.
- The dout sample for bit i is taken at the edge closing cycle k+1+i+BB_LAT.
- res_valid rises in cycle k+1+WIDTH+BB_LAT; accept-to-result latency is WIDTH+BB_LAT+1 cycles.
- res_ready already high when res_valid rises: the handshake completes that cycle, res_valid=0 and in_ready=1 the next cycle.
- Back-to-back throughput is one operand pair per WIDTH+BB_LAT+2 cycles with res_ready tied high.
- res_ready low: HOLD persists indefinitely with res unchanged.

## Configuration
- Macro: BB_DRV_PARITY_EN.
- Defined: adds output port res_par (1 bit), equal to the XOR of all WIDTH captured bits.
  - Computed incrementally per capture and valid whenever res_valid=1.
  - Resets to 0 and is cleared on entry to SHIFT.
- Undefined: no res_par port and no parity logic; all other behaviour is identical.

## Test plan
- Bench black-box model for all scenarios: dout = di_1 ^ di_2, delayed BB_LAT cycles.
- WIDTH=8, BB_LAT=0, a=8'hA5, b=8'h3C -> res=8'h99; res_valid asserted 9 cycles after accept; res_par=0 when BB_DRV_PARITY_EN is defined.
- WIDTH=8, BB_LAT=3, a=8'hFF, b=8'h01 -> res=8'hFE; res_valid 12 cycles after accept; di_1/di_2 are 0 during DRAIN.
- Hold res_ready low for 20 cycles in HOLD -> res stays constant, in_ready=0, and a new in_valid is not accepted. Then release -> in_ready=1 the next cycle.
- Pulse rst during the 4th SHIFT cycle -> the next cycle shows in_ready=1, res=0, res_valid=0. A following pair a=8'h0F, b=8'h00 -> res=8'h0F.
- Back-to-back pairs (8'h12, 8'h34), (8'hAB, 8'hCD) with in_valid and res_ready held high -> results 8'h26 then 8'h66, with accepts spaced 10 cycles apart at BB_LAT=0.

Source files
------------

// File: rtl/v_bb_bitserial_driver.sv
// v_bb_bitserial_driver: bit-serial driver/collector for a 2-in/1-out black-box cell; define BB_DRV_PARITY_EN to add res_par
module v_bb_bitserial_driver #(
  parameter int WIDTH = 8,
  parameter int BB_LAT = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             di_1,
  output logic             di_2,
  input  logic             dout,
  output logic [WIDTH-1:0] res,
  output logic             res_valid,
  input  logic             res_ready
`ifdef BB_DRV_PARITY_EN
  ,
  output logic             res_par
`endif
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, SHIFT, DRAIN, HOLD} state_t;
  state_t r_state, w_nxt;
  logic [WIDTH-1:0] r_a, r_b, r_res;
  logic [CW-1:0] r_cnt, r_ccnt;
  logic w_load, w_stb, w_cap, w_last_cap;
`ifdef BB_DRV_PARITY_EN
  logic r_par;
  assign res_par = r_par;
`endif
  assign w_load = r_state == IDLE && in_valid;
  assign w_stb = r_state == SHIFT;
  assign w_last_cap = w_cap && r_ccnt == CW'(WIDTH - 1);
  assign in_ready = r_state == IDLE;
  assign res_valid = r_state == HOLD;
  assign di_1 = w_stb && r_a[0];
  assign di_2 = w_stb && r_b[0];
  assign res = r_res;
  if (BB_LAT > 0) begin : g_dly
    logic [BB_LAT-1:0] r_dly;
    always_ff @(posedge clk)
      r_dly <= rst ? '0 : (r_dly << 1) | BB_LAT'(w_stb);
    assign w_cap = r_dly[BB_LAT-1];
  end else begin : g_nodly
    assign w_cap = w_stb;
  end
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      IDLE:  w_nxt = in_valid ? SHIFT : IDLE;
      SHIFT: w_nxt = r_cnt == CW'(WIDTH - 1) ? ((BB_LAT > 0) ? DRAIN : HOLD) : SHIFT;
      DRAIN: w_nxt = w_last_cap ? HOLD : DRAIN;
      HOLD:  w_nxt = res_ready ? IDLE : HOLD;
      default: w_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_a <= '0;
      r_b <= '0;
      r_cnt <= '0;
      r_ccnt <= '0;
      r_res <= '0;
`ifdef BB_DRV_PARITY_EN
      r_par <= 1'b0;
`endif
    end else begin
      r_state <= w_nxt;
      if (w_load) begin
        r_a <= a;
        r_b <= b;
        r_cnt <= '0;
        r_ccnt <= '0;
`ifdef BB_DRV_PARITY_EN
        r_par <= 1'b0;
`endif
      end else if (w_stb) begin
        r_a <= r_a >> 1;
        r_b <= r_b >> 1;
        r_cnt <= r_cnt + CW'(1);
      end
      if (w_cap) begin
        r_res <= {dout, r_res[WIDTH-1:1]};
        r_ccnt <= r_ccnt + CW'(1);
`ifdef BB_DRV_PARITY_EN
        r_par <= r_par ^ dout;
`endif
      end
    end
  end
endmodule

// File: tb/tb_v_bb_bitserial_driver.sv
// tb_v_bb_bitserial_driver: random and directed checks of two driver instances (BB_LAT 0 and 3) against an XOR black-box model
module tb_v_bb_bitserial_driver;
  localparam int W = 8;
  logic clk = 0, rst = 1;
  logic [W-1:0] a [2], b [2], res [2];
  logic [1:0] in_valid = '0, in_ready, di_1, di_2, dout, res_valid, res_ready = '0;
`ifdef BB_DRV_PARITY_EN
  logic [1:0] res_par;
`endif
  logic [2:0] pipe = '0;
  int n_chk = 0, n_err = 0;
  always #5 clk = ~clk;
  assign dout[0] = di_1[0] ^ di_2[0];
  assign dout[1] = pipe[2];
  always @(posedge clk) pipe <= {pipe[1:0], di_1[1] ^ di_2[1]};
  v_bb_bitserial_driver #(.WIDTH(W), .BB_LAT(0)) u0 (
    .clk(clk), .rst(rst), .a(a[0]), .b(b[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .di_1(di_1[0]), .di_2(di_2[0]), .dout(dout[0]), .res(res[0]), .res_valid(res_valid[0]),
    .res_ready(res_ready[0])
`ifdef BB_DRV_PARITY_EN
    , .res_par(res_par[0])
`endif
  );
  v_bb_bitserial_driver #(.WIDTH(W), .BB_LAT(3)) u1 (
    .clk(clk), .rst(rst), .a(a[1]), .b(b[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .di_1(di_1[1]), .di_2(di_2[1]), .dout(dout[1]), .res(res[1]), .res_valid(res_valid[1]),
    .res_ready(res_ready[1])
`ifdef BB_DRV_PARITY_EN
    , .res_par(res_par[1])
`endif
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic idle_chk(input int d);
    chk("rst_in_ready", in_ready[d], 1);
    chk("rst_res", res[d], 0);
    chk("rst_res_valid", res_valid[d], 0);
    chk("rst_di", {di_1[d], di_2[d]}, 0);
  endtask
  task automatic xfer(input int d, input logic [W-1:0] av, input logic [W-1:0] bv, input int hold);
    int n, lat;
    logic [W-1:0] d1, d2, r0;
    logic dnz, busy, stable, nacc;
    lat = d == 0 ? 0 : 3;
    @(negedge clk);
    a[d] = av;
    b[d] = bv;
    in_valid[d] = 1;
    res_ready[d] = hold == 0;
    n = 0;
    while (!in_ready[d] && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("accept_timeout", n >= 50, 0);
    @(negedge clk);
    in_valid[d] = 0;
    n = 1;
    d1 = 0;
    d2 = 0;
    dnz = 0;
    busy = 0;
    while (!res_valid[d] && n < 40) begin
      if (n <= W) begin
        d1[n-1] = di_1[d];
        d2[n-1] = di_2[d];
      end else dnz |= di_1[d] | di_2[d];
      busy |= in_ready[d];
      @(negedge clk);
      n++;
    end
    chk("latency", n, W + lat + 1);
    chk("di_1_bits", d1, av);
    chk("di_2_bits", d2, bv);
    chk("drain_di_zero", dnz, 0);
    chk("busy_in_ready", busy, 0);
    chk("res", res[d], av ^ bv);
`ifdef BB_DRV_PARITY_EN
    chk("res_par", res_par[d], ^(av ^ bv));
`endif
    if (hold > 0) begin
      r0 = res[d];
      a[d] = ~av;
      in_valid[d] = 1;
      stable = 1;
      nacc = 0;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        stable &= res[d] == r0 && res_valid[d];
        nacc |= in_ready[d];
      end
      chk("hold_stable", stable, 1);
      chk("hold_in_ready", nacc, 0);
      in_valid[d] = 0;
      res_ready[d] = 1;
    end
    @(negedge clk);
    chk("post_res_valid", res_valid[d], 0);
    chk("post_in_ready", in_ready[d], 1);
    res_ready[d] = 0;
  endtask
  initial begin
    logic [W-1:0] qa [$], qb [$], got [$];
    int acc [$];
    int cyc;
    a[0] = 0; b[0] = 0; a[1] = 0; b[1] = 0;
    repeat (3) @(negedge clk);
    rst = 0;
    @(negedge clk);
    idle_chk(0);
    idle_chk(1);
    xfer(0, 8'hA5, 8'h3C, 0);
    xfer(1, 8'hFF, 8'h01, 0);
    xfer(0, 8'($urandom), 8'($urandom), 20);
    xfer(1, 8'($urandom), 8'($urandom), 20);
    @(negedge clk);
    a[1] = 8'h5A;
    b[1] = 8'hC3;
    in_valid[1] = 1;
    @(negedge clk);
    in_valid[1] = 0;
    repeat (3) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    idle_chk(1);
    xfer(1, 8'h0F, 8'h00, 0);
    qa = '{8'h12, 8'hAB};
    qb = '{8'h34, 8'hCD};
    @(negedge clk);
    a[0] = qa[0];
    b[0] = qb[0];
    in_valid[0] = 1;
    res_ready[0] = 1;
    cyc = 0;
    while (got.size() < 2 && cyc < 60) begin
      if (acc.size() == 1 && cyc == acc[0] + 1) begin
        a[0] = qa[1];
        b[0] = qb[1];
      end
      if (acc.size() == 2 && cyc == acc[1] + 1) in_valid[0] = 0;
      if (res_valid[0]) got.push_back(res[0]);
      if (in_valid[0] && in_ready[0]) acc.push_back(cyc);
      @(negedge clk);
      cyc++;
    end
    in_valid[0] = 0;
    res_ready[0] = 0;
    chk("b2b_count", got.size(), 2);
    chk("b2b_accepts", acc.size(), 2);
    if (got.size() == 2) begin
      chk("b2b_res0", got[0], qa[0] ^ qb[0]);
      chk("b2b_res1", got[1], qa[1] ^ qb[1]);
    end
    if (acc.size() == 2) chk("b2b_spacing", acc[1] - acc[0], W + 2);
    for (int i = 0; i < 8; i++) xfer(i % 2, 8'($urandom), 8'($urandom), int'($urandom_range(0, 3)));
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
